// File: rtl/dc2_tag_assoc_if.sv
// Request/response bundle between the L2 controller and the set-associative tag array.
interface dc2_tag_assoc_if #(
  parameter int PADDR_W = 36,
  parameter int WAY_W   = 2
);
  // A request transfers on a clk edge where req_valid && req_rdy. The master holds
  // req_op/req_addr/req_excl stable while req_valid && !req_rdy. rsp_valid pulses for
  // exactly one cycle, one cycle after the transfer. Responses cannot be stalled.
  logic               req_valid;
  logic               req_rdy;
  logic [1:0]         req_op;
  logic [PADDR_W-1:0] req_addr;
  logic               req_excl;
  logic               rsp_valid;
  logic               rsp_hit;
  logic [WAY_W-1:0]   rsp_way;
  logic               rsp_excl;
  logic               rsp_dirty;
  logic               rsp_victim_valid;
  logic               rsp_victim_dirty;
  logic [PADDR_W-1:0] rsp_victim_addr;

  modport master (
    output req_valid, req_op, req_addr, req_excl,
    input  req_rdy, rsp_valid, rsp_hit, rsp_way, rsp_excl, rsp_dirty,
           rsp_victim_valid, rsp_victim_dirty, rsp_victim_addr
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_excl,
    output req_rdy, rsp_valid, rsp_hit, rsp_way, rsp_excl, rsp_dirty,
           rsp_victim_valid, rsp_victim_dirty, rsp_victim_addr
  );
endinterface

// File: rtl/dc2_tag_assoc.sv
// N-way set-associative L2 tag array: lookup / lookup-write / fill / invalidate,
// tree-PLRU replacement, and a one-set-per-cycle init sweep.
module dc2_tag_assoc #(
  parameter int PADDR_W = 36,
  parameter int SET_W   = 8,
  parameter int WAYS    = 4,
  parameter int WAY_W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic init_req,
  output logic init_busy,
  output logic o_dbg_state,
  dc2_tag_assoc_if.slave bus
);
  localparam int SETS  = 1 << SET_W;
  localparam int TAG_W = PADDR_W - SET_W;
  localparam int PL_W  = WAYS - 1;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_LKWR   = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_INIT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [SET_W-1:0] r_init_cnt, w_init_cnt_nxt;

  logic [WAYS-1:0][TAG_W-1:0] r_tag_mem   [SETS];
  logic [WAYS-1:0]            r_val_mem   [SETS];
  logic [WAYS-1:0]            r_dirty_mem [SETS];
  logic [WAYS-1:0]            r_excl_mem  [SETS];
  logic [PL_W-1:0]            r_plru_mem  [SETS];

  logic                       r_s1_valid;
  logic [1:0]                 r_s1_op;
  logic [PADDR_W-1:0]         r_s1_addr;
  logic                       r_s1_req_excl;
  logic [WAYS-1:0][TAG_W-1:0] r_s1_tag;
  logic [WAYS-1:0]            r_s1_val, r_s1_dirty, r_s1_excl;
  logic [PL_W-1:0]            r_s1_plru;

  logic [WAYS-1:0][TAG_W-1:0] w_nx_tag;
  logic [WAYS-1:0]            w_nx_val, w_nx_dirty, w_nx_excl;
  logic [PL_W-1:0]            w_nx_plru;

  logic             w_accept, w_bypass, w_hit, w_any_inv;
  logic [SET_W-1:0] w_req_set, w_s1_set;
  logic [TAG_W-1:0] w_s1_tag;
  logic [WAYS-1:0]  w_hit_vec;
  logic [WAY_W-1:0] w_hit_way, w_inv_way, w_alloc_way;

  // Point every node on the path away from way w.
  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] t, input logic [WAY_W-1:0] w);
    logic [PL_W-1:0]  r;
    logic [WAY_W-1:0] n;
    logic             d;
    r = t;
    n = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d    = w[WAY_W-1-l];
      r[n] = ~d;
      n    = WAY_W'(2 * n + 1 + d);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] t);
    logic [WAY_W-1:0] v;
    logic [WAY_W-1:0] n;
    logic             d;
    v = '0;
    n = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d            = t[n];
      v[WAY_W-1-l] = d;
      n            = WAY_W'(2 * n + 1 + d);
    end
    return v;
  endfunction

  assign init_busy   = (r_state == ST_INIT);
  assign o_dbg_state = r_state;
  assign bus.req_rdy = (r_state == ST_IDLE);
  assign w_accept    = bus.req_valid && bus.req_rdy;
  assign w_req_set   = bus.req_addr[SET_W-1:0];
  assign w_s1_set    = r_s1_addr[SET_W-1:0];
  assign w_s1_tag    = r_s1_addr[PADDR_W-1:SET_W];
  // Same-set back-to-back: stage 0 takes stage 1's pending update instead of the array.
  assign w_bypass    = r_s1_valid && (w_s1_set == w_req_set);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_IDLE: if (init_req) begin
        w_state_nxt    = ST_INIT;
        w_init_cnt_nxt = '0;
      end
      default: begin
        w_init_cnt_nxt = r_init_cnt + 1'b1;
        if (&r_init_cnt) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    w_hit_vec = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_hit_vec[w] = r_s1_val[w] && (r_s1_tag[w] == w_s1_tag);
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
      if (!r_s1_val[w]) begin
        w_inv_way = WAY_W'(w);
        w_any_inv = 1'b1;
      end
    end
  end

  assign w_hit       = |w_hit_vec;
  assign w_alloc_way = w_any_inv ? w_inv_way : plru_victim(r_s1_plru);

  always_comb begin
    w_nx_tag   = r_s1_tag;
    w_nx_val   = r_s1_val;
    w_nx_dirty = r_s1_dirty;
    w_nx_excl  = r_s1_excl;
    w_nx_plru  = r_s1_plru;
    case (r_s1_op)
      OP_LOOKUP: if (w_hit) w_nx_plru = plru_touch(r_s1_plru, w_hit_way);
      OP_LKWR: if (w_hit) begin
        w_nx_dirty[w_hit_way] = 1'b1;
        w_nx_plru             = plru_touch(r_s1_plru, w_hit_way);
      end
      OP_FILL: if (w_hit) begin
        w_nx_excl[w_hit_way] = r_s1_req_excl;
        w_nx_plru            = plru_touch(r_s1_plru, w_hit_way);
      end else begin
        w_nx_tag[w_alloc_way]   = w_s1_tag;
        w_nx_val[w_alloc_way]   = 1'b1;
        w_nx_dirty[w_alloc_way] = 1'b0;
        w_nx_excl[w_alloc_way]  = r_s1_req_excl;
        w_nx_plru               = plru_touch(r_s1_plru, w_alloc_way);
      end
      default: if (w_hit) begin
        w_nx_val[w_hit_way]   = 1'b0;
        w_nx_dirty[w_hit_way] = 1'b0;
        w_nx_excl[w_hit_way]  = 1'b0;
      end
    endcase
  end

  // The sweep owns the array while it runs; a straggling stage-1 write is dropped.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_tag_mem[r_init_cnt]   <= '0;
      r_val_mem[r_init_cnt]   <= '0;
      r_dirty_mem[r_init_cnt] <= '0;
      r_excl_mem[r_init_cnt]  <= '0;
      r_plru_mem[r_init_cnt]  <= '0;
    end else if (r_s1_valid) begin
      r_tag_mem[w_s1_set]   <= w_nx_tag;
      r_val_mem[w_s1_set]   <= w_nx_val;
      r_dirty_mem[w_s1_set] <= w_nx_dirty;
      r_excl_mem[w_s1_set]  <= w_nx_excl;
      r_plru_mem[w_s1_set]  <= w_nx_plru;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_op       <= '0;
      r_s1_addr     <= '0;
      r_s1_req_excl <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op       <= bus.req_op;
        r_s1_addr     <= bus.req_addr;
        r_s1_req_excl <= bus.req_excl;
        if (w_bypass) begin
          r_s1_tag   <= w_nx_tag;
          r_s1_val   <= w_nx_val;
          r_s1_dirty <= w_nx_dirty;
          r_s1_excl  <= w_nx_excl;
          r_s1_plru  <= w_nx_plru;
        end else begin
          r_s1_tag   <= r_tag_mem[w_req_set];
          r_s1_val   <= r_val_mem[w_req_set];
          r_s1_dirty <= r_dirty_mem[w_req_set];
          r_s1_excl  <= r_excl_mem[w_req_set];
          r_s1_plru  <= r_plru_mem[w_req_set];
        end
      end
    end
  end

  assign bus.rsp_valid        = r_s1_valid;
  assign bus.rsp_hit          = r_s1_valid && w_hit;
  assign bus.rsp_way          = r_s1_valid ? (w_hit ? w_hit_way : w_alloc_way) : '0;
  assign bus.rsp_excl         = r_s1_valid && w_hit && r_s1_excl[w_hit_way];
  assign bus.rsp_dirty        = r_s1_valid && w_hit && r_s1_dirty[w_hit_way];
  assign bus.rsp_victim_valid = r_s1_valid && (r_s1_op == OP_FILL) && !w_hit && r_s1_val[w_alloc_way];
  assign bus.rsp_victim_dirty = bus.rsp_victim_valid && r_s1_dirty[w_alloc_way];
  assign bus.rsp_victim_addr  = bus.rsp_victim_valid ? {r_s1_tag[w_alloc_way], w_s1_set} : '0;

  a_single_hit: assert property (@(posedge clk) disable iff (!rst) r_s1_valid |-> $onehot0(w_hit_vec));
endmodule
